// File: rtl/seg_msg_sched.sv
// Round-robin owner of the 4-digit seven-segment display: grants one of three
// requesters for a fixed dwell, optionally blinking, and drives the nibble bus.
module seg_msg_sched #(
    parameter int          HOLD_TICKS   = 380,
    parameter int          BLINK_TICKS  = 95,
    parameter logic [15:0] IDLE_PATTERN = 16'hFFFF
) (
    input  logic        clk190hz,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  blink,
    input  logic [15:0] msg0,
    input  logic [15:0] msg1,
    input  logic [15:0] msg2,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic [15:0] dataBus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] BLINK_LEN = 16'(BLINK_TICKS);

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  owner;
    logic [15:0] hold_cnt;
    logic [15:0] blink_cnt;
    logic        blink_on;

    logic        owner_req;
    logic        owner_blink;
    logic [15:0] owner_msg;
    logic [2:0]  owner_hot;
    logic [1:0]  win;
    logic [15:0] win_msg;
    logic [2:0]  win_hot;
    logic [15:0] blink_inc;
    logic [15:0] blink_nxt;
    logic        blink_on_nxt;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : (i + 2'd1);
    endfunction

    // Search order starts at the pointer and wraps 0->1->2->0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] i1;
        logic [1:0] i2;
        i1 = next_idx(p);
        i2 = next_idx(i1);
        if (r[p])
            return p;
        else if (r[i1])
            return i1;
        else
            return i2;
    endfunction

    // Owner/winner multiplexing and next blink phase.
    always_comb begin
        owner_req   = 1'b0;
        owner_blink = 1'b0;
        owner_msg   = IDLE_PATTERN;
        owner_hot   = 3'b000;
        case (owner)
            2'd0: begin owner_req = req[0]; owner_blink = blink[0]; owner_msg = msg0; owner_hot = 3'b001; end
            2'd1: begin owner_req = req[1]; owner_blink = blink[1]; owner_msg = msg1; owner_hot = 3'b010; end
            2'd2: begin owner_req = req[2]; owner_blink = blink[2]; owner_msg = msg2; owner_hot = 3'b100; end
            default: begin owner_req = 1'b0; owner_msg = IDLE_PATTERN; end
        endcase

        win     = rr_pick(req, ptr);
        win_msg = IDLE_PATTERN;
        win_hot = 3'b000;
        case (win)
            2'd0: begin win_msg = msg0; win_hot = 3'b001; end
            2'd1: begin win_msg = msg1; win_hot = 3'b010; end
            2'd2: begin win_msg = msg2; win_hot = 3'b100; end
            default: begin win_msg = IDLE_PATTERN; win_hot = 3'b000; end
        endcase

        blink_inc = blink_cnt + 16'd1;
        if (blink_inc == BLINK_LEN) begin
            blink_nxt    = 16'd0;
            blink_on_nxt = ~blink_on;
        end else begin
            blink_nxt    = blink_inc;
            blink_on_nxt = blink_on;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk190hz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 3'b000;
            done      <= 3'b000;
            busy      <= 1'b0;
            dataBus   <= IDLE_PATTERN;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            hold_cnt  <= 16'd0;
            blink_cnt <= 16'd0;
            blink_on  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 3'b000;
                    hold_cnt  <= 16'd0;
                    blink_cnt <= 16'd0;
                    blink_on  <= 1'b1;
                    if (req != 3'b000) begin
                        grant   <= win_hot;
                        owner   <= win;
                        dataBus <= win_msg;
                        ptr     <= next_idx(win);
                        busy    <= 1'b1;
                        state   <= SHOW;
                    end else begin
                        grant   <= 3'b000;
                        busy    <= 1'b0;
                        dataBus <= IDLE_PATTERN;
                        state   <= IDLE;
                    end
                end
                SHOW: begin
                    busy <= 1'b1;
                    if (!owner_req) begin
                        // Owner withdrew: release without signalling completion.
                        state   <= GAP;
                        grant   <= 3'b000;
                        done    <= 3'b000;
                        dataBus <= IDLE_PATTERN;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state   <= GAP;
                        grant   <= 3'b000;
                        done    <= owner_hot;
                        dataBus <= IDLE_PATTERN;
                    end else begin
                        hold_cnt  <= hold_cnt + 16'd1;
                        blink_cnt <= blink_nxt;
                        blink_on  <= blink_on_nxt;
                        done      <= 3'b000;
                        if (owner_blink && !blink_on_nxt)
                            dataBus <= IDLE_PATTERN;
                        else
                            dataBus <= owner_msg;
                    end
                end
                GAP: begin
                    state   <= IDLE;
                    grant   <= 3'b000;
                    done    <= 3'b000;
                    busy    <= 1'b0;
                    dataBus <= IDLE_PATTERN;
                end
                default: begin
                    state   <= IDLE;
                    grant   <= 3'b000;
                    done    <= 3'b000;
                    busy    <= 1'b0;
                    dataBus <= IDLE_PATTERN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_msg_sched.sv
// Directed self-checking bench for seg_msg_sched with HOLD_TICKS=4, BLINK_TICKS=2.
module tb_seg_msg_sched;

    logic        clk190hz = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  blink;
    logic [15:0] msg0;
    logic [15:0] msg1;
    logic [15:0] msg2;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic [15:0] dataBus;

    int passed = 0;
    int total  = 0;

    seg_msg_sched #(
        .HOLD_TICKS  (4),
        .BLINK_TICKS (2),
        .IDLE_PATTERN(16'hFFFF)
    ) dut (
        .clk190hz(clk190hz),
        .rst     (rst),
        .req     (req),
        .blink   (blink),
        .msg0    (msg0),
        .msg1    (msg1),
        .msg2    (msg2),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .dataBus (dataBus)
    );

    always #5 clk190hz = ~clk190hz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk190hz);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, {13'd0, grant}, 16'h0000);
        chk({tag, ".done"},  {13'd0, done},  16'h0000);
        chk({tag, ".busy"},  {15'd0, busy},  16'h0000);
        chk({tag, ".bus"},   dataBus,        16'hFFFF);
    endtask

    logic [2:0]  rr_seq [4]   = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [15:0] blink_exp [4] = '{16'hABCD, 16'hABCD, 16'hFFFF, 16'hFFFF};

    initial begin
        rst = 1'b1; req = 3'b000; blink = 3'b000;
        msg0 = 16'h0000; msg1 = 16'h0000; msg2 = 16'h0000;
        step(2);
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_idle("noreq");
        end

        // Single requester: dwell, done pulse, regrant 6 edges after the first grant.
        msg0 = 16'h1234; req = 3'b001;
        step(1);
        chk("r0.grant", {13'd0, grant}, 16'h0001);
        chk("r0.busy",  {15'd0, busy},  16'h0001);
        for (int i = 0; i < 4; i++) begin
            chk("r0.bus",  dataBus,        16'h1234);
            chk("r0.done", {13'd0, done},  16'h0000);
            step(1);
        end
        chk("r0.done_pulse", {13'd0, done},  16'h0001);
        chk("r0.done_bus",   dataBus,        16'hFFFF);
        chk("r0.done_grant", {13'd0, grant}, 16'h0000);
        chk("r0.gap_busy",   {15'd0, busy},  16'h0001);
        step(1);
        chk_idle("r0.gap_exit");
        step(1);
        chk("r0.regrant", {13'd0, grant}, 16'h0001);

        // All three requesting: round-robin 001,010,100,001.
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            chk("rr.grant", {13'd0, grant}, {13'd0, rr_seq[k]});
            step(4);
            chk("rr.done",  {13'd0, done},  {13'd0, rr_seq[k]});
            chk("rr.ungrant", {13'd0, grant}, 16'h0000);
            step(1);
            chk("rr.idle_busy", {15'd0, busy}, 16'h0000);
            chk("rr.done_clr",  {13'd0, done}, 16'h0000);
            if (k == 3) req = 3'b000;
            step(1);
        end
        chk("rr.stop", {13'd0, grant}, 16'h0000);

        // Live message tracking for requester 1.
        msg1 = 16'h0000; req = 3'b010;
        step(1);
        chk("r1.grant", {13'd0, grant}, 16'h0002);
        chk("r1.bus0",  dataBus,        16'h0000);
        msg1 = 16'h0009;
        step(1);
        chk("r1.bus9",  dataBus,        16'h0009);
        step(3);
        chk("r1.done",  {13'd0, done},  16'h0002);
        req = 3'b000;
        step(2);

        // Blinking requester 2.
        msg2 = 16'hABCD; blink = 3'b100; req = 3'b100;
        step(1);
        chk("r2.grant", {13'd0, grant}, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            chk("r2.blink", dataBus, blink_exp[i]);
            step(1);
        end
        chk("r2.done", {13'd0, done}, 16'h0004);
        req = 3'b000; blink = 3'b000;
        step(2);

        // Owner 0 withdraws at its 2nd SHOW cycle; pending requester 1 follows.
        msg0 = 16'h5678; req = 3'b011;
        step(1);
        chk("ab.grant", {13'd0, grant}, 16'h0001);
        chk("ab.bus",   dataBus,        16'h5678);
        step(1);
        req = 3'b010;
        step(1);
        chk("ab.ungrant", {13'd0, grant}, 16'h0000);
        chk("ab.nodone",  {13'd0, done},  16'h0000);
        chk("ab.gapbusy", {15'd0, busy},  16'h0001);
        chk("ab.gapbus",  dataBus,        16'hFFFF);
        step(1);
        chk("ab.idle_busy", {15'd0, busy}, 16'h0000);
        chk("ab.idle_done", {13'd0, done}, 16'h0000);
        step(1);
        chk("ab.next", {13'd0, grant}, 16'h0002);

        // Reset mid-SHOW clears immediately and restores requester-0 priority.
        step(1);
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        step(1);
        rst = 1'b0; req = 3'b011;
        step(1);
        chk("midrst.prio", {13'd0, grant}, 16'h0001);
        chk("midrst.bus",  dataBus,        16'h5678);
        req = 3'b000;
        step(3);
        chk_idle("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
